or_acc16: RTL and testbench

OR_ACC16 -- requirements
Module: or_acc16

---
 rtl/or_acc16.sv | 123 ++++++++++++
 tb/tb_or_acc16.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/or_acc16.sv
// or_acc16: collects a burst of 1..2^LEN_W sixteen-bit words and presents
// their bitwise OR, together with the reduction OR and reduction AND of that
// result. The control is a three-state FSM (IDLE -> ACC -> DONE).
//
// Handshake semantics: a word moves on a rising edge where in_valid and
// in_ready are both 1. The result is taken on a rising edge where out_valid
// and out_ready are both 1. in_ready and out_valid are functions of the
// current state only. They never depend combinationally on in_valid or
// out_ready. While out_valid is high the result holds steady until it is
// taken.
module or_acc16 #(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   input  logic [15:0]      in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [15:0]      out_data,
   input  logic             out_ready,
   output logic             out_any,
   output logic             out_all,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [15:0]      acc;
   logic [15:0]      acc_next;
   // The counter and the latched length are one bit wider than len.
   // A length of 2^LEN_W is then held as a real value and does not wrap.
   logic [LEN_W:0]   cnt;
   logic [LEN_W:0]   cnt_next;
   logic [LEN_W:0]   len_q;
   logic [LEN_W:0]   len_q_next;
   logic [LEN_W:0]   cnt_inc;
   logic [LEN_W:0]   len_ext;

   // An encoded length of 0 stands for the full 2^LEN_W words.
   assign len_ext = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
   assign cnt_inc = cnt + {{LEN_W{1'b0}}, 1'b1};

   // State, accumulator, counter and latched length registers with async clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         len_q <= '0;
      end else begin
         state <= state_next;
         acc   <= acc_next;
         cnt   <= cnt_next;
         len_q <= len_q_next;
      end
   end

   // Next-state logic: burst start, word accumulation, and result hand-off.
   always_comb begin
      state_next = state;
      acc_next   = acc;
      cnt_next   = cnt;
      len_q_next = len_q;
      case (state)
         IDLE: begin
            if (start) begin
               len_q_next = len_ext;
               acc_next   = '0;
               cnt_next   = '0;
               state_next = ACC;
            end
         end
         ACC: begin
            // start is ignored here. Cycles with in_valid low hold everything.
            if (in_valid) begin
               acc_next = acc | in_data;
               cnt_next = cnt_inc;
               if (cnt_inc == len_q) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            // A new start only counts once the pending result is taken.
            if (out_ready) begin
               if (start) begin
                  len_q_next = len_ext;
                  acc_next   = '0;
                  cnt_next   = '0;
                  state_next = ACC;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs come from the state alone. out_data is forced to 0 outside DONE.
   always_comb begin
      in_ready  = (state == ACC);
      out_valid = (state == DONE);
      busy      = (state == ACC) || (state == DONE);
      out_data  = (state == DONE) ? acc : 16'h0000;
      out_any   = |out_data;
      out_all   = &out_data;
      dbg_state = state;
   end

endmodule

// File: tb/tb_or_acc16.sv
// tb_or_acc16: directed burst table, hand-written corner sequences, then a
// randomized run compared against a queue-based model of pending results.
module tb_or_acc16;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  len;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready;
   logic        out_any;
   logic        out_all;
   logic        busy;
   logic [1:0]  dbg_state;

   int checks   = 0;
   int failures = 0;

   or_acc16 #(.LEN_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .out_any   (out_any),
      .out_all   (out_all),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // Clock generation: 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]       len;
      logic [3:0][15:0] words;
      logic [15:0]      exp_data;
      logic             exp_any;
      logic             exp_all;
   } vec_t;

   vec_t tbl [7];

   // Scoreboard: results the model expects the DUT to present, oldest first.
   logic [15:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Move to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_burst(input logic [3:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] d);
      int n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      check("done_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   function automatic vec_t mk(input logic [3:0] l, input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input logic [15:0] w3,
                               input logic [15:0] e, input logic a, input logic al);
      vec_t v;
      v.len      = l;
      v.words[0] = w0;
      v.words[1] = w1;
      v.words[2] = w2;
      v.words[3] = w3;
      v.exp_data = e;
      v.exp_any  = a;
      v.exp_all  = al;
      return v;
   endfunction

   // Stimulus and checking sequence.
   initial begin
      int lat;
      logic [15:0] held;
      logic        m_collect;
      int          m_left;
      logic [15:0] m_acc;
      logic        have;
      logic [15:0] exp_d;

      rst_n = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      check("reset_outputs", {13'd0, in_ready, out_valid, out_data, out_any, out_all, busy}, 32'd0);
      check("reset_state", 32'(dbg_state), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      check("idle_wait", {in_ready, out_valid, busy}, 3'b000);

      // Table-driven bursts.
      tbl[0] = mk(4'd1, 16'hBEEF, 16'h0, 16'h0, 16'h0, 16'hBEEF, 1'b1, 1'b0);
      tbl[1] = mk(4'd2, 16'h00F0, 16'h0F00, 16'h0, 16'h0, 16'h0FF0, 1'b1, 1'b0);
      tbl[2] = mk(4'd3, 16'h8000, 16'h0001, 16'h0000, 16'h0, 16'h8001, 1'b1, 1'b0);
      tbl[3] = mk(4'd4, 16'hF000, 16'h0F00, 16'h00F0, 16'h000F, 16'hFFFF, 1'b1, 1'b1);
      tbl[4] = mk(4'd2, 16'h0000, 16'h0000, 16'h0, 16'h0, 16'h0000, 1'b0, 1'b0);
      tbl[5] = mk(4'd4, 16'h1234, 16'h1234, 16'h4321, 16'h0000, 16'h5335, 1'b1, 1'b0);
      tbl[6] = mk(4'd1, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'hFFFF, 1'b1, 1'b1);
      for (int t = 0; t < 7; t++) begin
         start_burst(tbl[t].len);
         for (int i = 0; i < int'(tbl[t].len); i++) begin
            check("tbl_not_early", 32'(out_valid), 32'd0);
            send_word(tbl[t].words[i]);
         end
         wait_done();
         check("tbl_data", {out_data, out_any, out_all, busy, in_ready},
               {tbl[t].exp_data, tbl[t].exp_any, tbl[t].exp_all, 1'b1, 1'b0});
         take_result();
         check("tbl_back_idle", {15'd0, out_data, busy, out_valid}, 32'd0);
      end

      // Latency: three words back-to-back, result visible four edges after start.
      start = 1'b1; len = 4'd3;
      tick();
      start = 1'b0; lat = 1;
      in_valid = 1'b1; in_data = 16'h0001; tick(); lat++;
      in_data = 16'h0010; tick(); lat++;
      in_data = 16'h0100; tick(); lat++;
      in_valid = 1'b0;
      check("lat_valid", 32'(out_valid), 32'd1);
      check("lat_cycles", 32'(lat), 32'd4);
      check("lat_data", {out_data, out_any, out_all}, {16'h0111, 1'b1, 1'b0});
      take_result();

      // Gaps inside a burst keep in_ready high and do not disturb the result.
      start_burst(4'd2);
      send_word(16'hFF00);
      tick();
      check("gap1_ready", {in_ready, out_valid}, 2'b10);
      tick();
      check("gap2_ready", {in_ready, out_valid}, 2'b10);
      send_word(16'h00FF);
      check("gap_data", {out_data, out_all, out_valid}, {16'hFFFF, 1'b1, 1'b1});
      take_result();

      // len=0 means a 16-word burst. A 17th word must be refused.
      start_burst(4'd0);
      for (int i = 0; i < 16; i++) begin
         check("full_not_early", 32'(out_valid), 32'd0);
         send_word(16'h0000);
      end
      check("full_done", {out_valid, out_data, out_any}, {1'b1, 16'h0000, 1'b0});
      in_valid = 1'b1; in_data = 16'hFFFF;
      check("full_17th_refused", 32'(in_ready), 32'd0);
      tick();
      in_valid = 1'b0;
      check("full_17th_no_effect", {out_valid, out_data}, {1'b1, 16'h0000});
      take_result();

      // Backpressure in DONE, then a back-to-back burst.
      start_burst(4'd1);
      send_word(16'h1234);
      held = out_data;
      in_valid = 1'b1; in_data = 16'hFFFF; start = 1'b1; len = 4'd3;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_stable", {out_valid, in_ready, out_data}, {1'b1, 1'b0, held});
      end
      check("hold_value", 32'(held), 32'h1234);
      in_valid = 1'b0; out_ready = 1'b1; start = 1'b1; len = 4'd1;
      tick();
      out_ready = 1'b0; start = 1'b0;
      check("b2b_in_acc", {in_ready, out_valid, busy}, 3'b101);
      send_word(16'hA5A5);
      check("b2b_data", {out_valid, out_data}, {1'b1, 16'hA5A5});
      take_result();

      // Asynchronous reset in the middle of a burst.
      start_burst(4'd4);
      send_word(16'h0F0F);
      send_word(16'hF000);
      check("pre_reset_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_reset_outputs", {13'd0, in_ready, out_valid, out_data, out_any, out_all, busy}, 32'd0);
      tick();
      #1 rst_n = 1'b1;
      tick();
      check("post_reset_idle", {in_ready, out_valid, busy}, 3'b000);
      start_burst(4'd1);
      send_word(16'h8000);
      check("post_reset_fresh", {out_valid, out_data}, {1'b1, 16'h8000});
      take_result();

      // start during ACC is ignored.
      start_burst(4'd3);
      send_word(16'h0001);
      start = 1'b1; len = 4'd1;
      tick();
      start = 1'b0;
      check("acc_start_ignored", {in_ready, out_valid}, 2'b10);
      send_word(16'h0002);
      check("acc_len_kept", 32'(out_valid), 32'd0);
      send_word(16'h0004);
      check("acc_start_data", {out_valid, out_data}, {1'b1, 16'h0007});
      take_result();

      // Randomized run against a model of collecting state plus pending results.
      m_collect = 1'b0; m_left = 0; m_acc = '0;
      exp_q.delete();
      for (int c = 0; c < 3000; c++) begin
         start     = ($urandom_range(0, 3) == 0);
         len       = 4'($urandom_range(0, 15));
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom & $urandom);
         out_ready = ($urandom_range(0, 1) == 1);
         have  = (exp_q.size() != 0);
         exp_d = have ? exp_q[0] : 16'h0000;
         check("rnd_ctrl", {in_ready, out_valid, busy}, {m_collect, have, m_collect | have});
         check("rnd_data", {out_data, out_any, out_all}, {exp_d, |exp_d, &exp_d});
         if (have && out_ready) begin
            void'(exp_q.pop_front());
            if (start) begin
               m_collect = 1'b1; m_acc = '0; m_left = (len == 0) ? 16 : int'(len);
            end
         end else if (!m_collect && !have) begin
            if (start) begin
               m_collect = 1'b1; m_acc = '0; m_left = (len == 0) ? 16 : int'(len);
            end
         end else if (m_collect && in_valid) begin
            m_acc  = m_acc | in_data;
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_collect = 1'b0;
               exp_q.push_back(m_acc);
            end
         end
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
